// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - program counter register and instruction fetch controller
// Fetches the word at pc over req/ack, holds it in ir and offers it downstream via valid/ready.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [29:0] pc,
  output logic [31:0] ir,
  input  logic [29:0] npc_in,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        flush,
  input  logic [29:0] flush_pc,
  output logic        fetch_err
);

  typedef enum logic [1:0] {IDLE, REQ, VALID, ERR} state_t;

  localparam logic [29:0] RESET_WPC = RESET_PC[31:2];
  localparam logic [7:0]  WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  logic [29:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [7:0]  wait_q, wait_d;
  logic        req_q, valid_q, err_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    wait_d  = wait_q;
    if (state_q == IDLE) begin
      state_d = REQ;
      wait_d  = '0;
    end else if (flush) begin
      // Redirect wins over any same-cycle ack or accept.
      pc_d    = flush_pc;
      wait_d  = '0;
      state_d = REQ;
    end else begin
      case (state_q)
        REQ: begin
          if (imem_ack) begin
            ir_d    = imem_rdata;
            state_d = VALID;
          end else if (wait_q == WAIT_LAST) begin
            state_d = ERR;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
        VALID: begin
          if (inst_ready) begin
            pc_d    = npc_in;
            wait_d  = '0;
            state_d = REQ;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_WPC;
      ir_q    <= '0;
      wait_q  <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      wait_q  <= wait_d;
      req_q   <= (state_d == REQ);
      valid_q <= (state_d == VALID);
      err_q   <= (state_d == ERR);
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign ir         = ir_q;
  assign inst_valid = valid_q;
  assign fetch_err  = err_q;

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - self-checking bench for pc_fetch
// Directed boot/backpressure/branch/timeout/flush cases followed by randomized fetch traffic.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst, imem_ack, inst_ready, flush;
  logic [31:0] imem_rdata;
  logic [29:0] npc_in, flush_pc;
  logic        imem_req, inst_valid, fetch_err;
  logic [29:0] imem_addr, pc;
  logic [31:0] ir;

  logic        rst4, ack4, flush4;
  logic [31:0] rdata4;
  logic [29:0] fpc4;
  logic        req4, valid4, err4;
  logic [29:0] addr4, pc4;
  logic [31:0] ir4;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned ncyc     = 0;
  logic [29:0] exp_pc;
  logic [31:0] exp_ir;

  always #5 clk = ~clk;

  pc_fetch #(.RESET_PC(32'h0000_3000), .MAX_WAIT(16)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(pc), .ir(ir),
    .npc_in(npc_in), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .flush(flush), .flush_pc(flush_pc), .fetch_err(fetch_err)
  );

  pc_fetch #(.RESET_PC(32'h0000_3000), .MAX_WAIT(4)) dut4 (
    .clk(clk), .rst(rst4), .imem_req(req4), .imem_addr(addr4),
    .imem_ack(ack4), .imem_rdata(rdata4), .pc(pc4), .ir(ir4),
    .npc_in(npc_in), .inst_valid(valid4), .inst_ready(inst_ready),
    .flush(flush4), .flush_pc(fpc4), .fetch_err(err4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  // Starts in REQ at exp_pc; lat no-ack cycles, then ack with word.
  task automatic fetch_ack(input int lat, input logic [31:0] word);
    for (int i = 0; i < lat; i++) begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      tick();
      check_eq("wait_req", {31'b0, imem_req}, 32'd1);
      check_eq("wait_addr", {2'b0, imem_addr}, {2'b0, exp_pc});
      check_eq("wait_ir", ir, exp_ir);
      check_eq("wait_err", {31'b0, fetch_err}, 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    exp_ir     = word;
    check_eq("ack_valid", {31'b0, inst_valid}, 32'd1);
    check_eq("ack_req", {31'b0, imem_req}, 32'd0);
    check_eq("ack_ir", ir, exp_ir);
    check_eq("ack_pc", {2'b0, pc}, {2'b0, exp_pc});
  endtask

  // Starts in VALID; hold cycles of backpressure, then accept loading next.
  task automatic accept(input int hold, input logic [29:0] next);
    npc_in = next;
    for (int i = 0; i < hold; i++) begin
      inst_ready = 1'b0;
      tick();
      check_eq("hold_valid", {31'b0, inst_valid}, 32'd1);
      check_eq("hold_pc", {2'b0, pc}, {2'b0, exp_pc});
      check_eq("hold_ir", ir, exp_ir);
      check_eq("hold_req", {31'b0, imem_req}, 32'd0);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    exp_pc = next;
    check_eq("acc_req", {31'b0, imem_req}, 32'd1);
    check_eq("acc_addr", {2'b0, imem_addr}, {2'b0, exp_pc});
    check_eq("acc_valid", {31'b0, inst_valid}, 32'd0);
  endtask

  // Flush from REQ (from_valid=0) or VALID (from_valid=1), optionally colliding with ack/accept.
  task automatic do_flush(input bit from_valid, input bit collide, input logic [29:0] tgt,
                          input logic [31:0] word);
    flush    = 1'b1;
    flush_pc = tgt;
    if (from_valid) begin
      inst_ready = collide;
      npc_in     = 30'($urandom);
    end else begin
      imem_ack   = collide;
      imem_rdata = word;
    end
    tick();
    flush      = 1'b0;
    inst_ready = 1'b0;
    imem_ack   = 1'b0;
    exp_pc     = tgt;
    check_eq("fl_req", {31'b0, imem_req}, 32'd1);
    check_eq("fl_addr", {2'b0, imem_addr}, {2'b0, exp_pc});
    check_eq("fl_ir", ir, exp_ir);
    check_eq("fl_valid", {31'b0, inst_valid}, 32'd0);
    check_eq("fl_err", {31'b0, fetch_err}, 32'd0);
  endtask

  initial begin
    int unsigned c0;
    rst = 1'b0; imem_ack = 1'b0; imem_rdata = '0; npc_in = '0; inst_ready = 1'b0;
    flush = 1'b0; flush_pc = '0;
    rst4 = 1'b0; ack4 = 1'b0; rdata4 = '0; flush4 = 1'b0; fpc4 = '0;

    repeat (3) tick();
    check_eq("rst_req", {31'b0, imem_req}, 32'd0);
    check_eq("rst_valid", {31'b0, inst_valid}, 32'd0);
    check_eq("rst_err", {31'b0, fetch_err}, 32'd0);
    check_eq("rst_pc", {2'b0, pc}, 32'h0000_0C00);
    check_eq("rst_ir", ir, 32'd0);

    rst = 1'b1;
    #1;
    check_eq("boot_idle_req", {31'b0, imem_req}, 32'd0);
    tick();
    check_eq("boot_req", {31'b0, imem_req}, 32'd1);
    check_eq("boot_addr", {2'b0, imem_addr}, 32'h0000_0C00);
    exp_pc = 30'h0C00;
    exp_ir = 32'd0;
    fetch_ack(0, 32'h2008_0005);
    accept(4, 30'h0C01);

    fetch_ack(0, 32'h1000_FFFE);
    accept(0, 30'h0BFF);

    c0 = ncyc;
    for (int k = 0; k < 4; k++) begin
      fetch_ack(0, 32'h2400_0000 | k);
      accept(0, exp_pc + 30'd1);
    end
    check_eq("stream_cycles", ncyc - c0, 32'd8);

    fetch_ack(5, 32'h8C09_0010);
    accept(1, exp_pc + 30'd1);

    do_flush(1'b0, 1'b1, 30'h0100, 32'hDEAD_BEEF);
    fetch_ack(0, 32'h0123_4567);
    do_flush(1'b1, 1'b1, 30'h0200, 32'h0);

    rst4 = 1'b1;
    tick();
    check_eq("to_req1", {31'b0, req4}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("to_req", {31'b0, req4}, 32'd1);
      check_eq("to_noerr", {31'b0, err4}, 32'd0);
    end
    tick();
    check_eq("to_err", {31'b0, err4}, 32'd1);
    check_eq("to_req_off", {31'b0, req4}, 32'd0);
    ack4 = 1'b1; rdata4 = 32'hDEAD_BEEF;
    tick(); tick();
    ack4 = 1'b0;
    check_eq("to_err_hold", {31'b0, err4}, 32'd1);
    check_eq("to_ack_ign_ir", ir4, 32'd0);
    check_eq("to_ack_ign_valid", {31'b0, valid4}, 32'd0);
    check_eq("to_pc_hold", {2'b0, pc4}, 32'h0000_0C00);
    flush4 = 1'b1; fpc4 = 30'h0060;
    tick();
    flush4 = 1'b0;
    check_eq("rec_err", {31'b0, err4}, 32'd0);
    check_eq("rec_req", {31'b0, req4}, 32'd1);
    check_eq("rec_addr", {2'b0, addr4}, 32'h0000_0060);
    rst4 = 1'b0;

    for (int n = 0; n < 150; n++) begin
      int unsigned op;
      op = $urandom_range(0, 9);
      if (op == 0) begin
        do_flush(1'b0, 1'($urandom_range(0, 1)), 30'($urandom), $urandom);
      end else begin
        fetch_ack(int'($urandom_range(0, 6)), $urandom);
        if (op == 1)
          do_flush(1'b1, 1'($urandom_range(0, 1)), 30'($urandom), 32'h0);
        else
          accept(int'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) != 0) ? exp_pc + 30'd1 : 30'($urandom));
      end
    end

    rst = 1'b0;
    #1;
    check_eq("mid_rst_req", {31'b0, imem_req}, 32'd0);
    check_eq("mid_rst_pc", {2'b0, pc}, 32'h0000_0C00);
    check_eq("mid_rst_ir", ir, 32'd0);
    check_eq("mid_rst_valid", {31'b0, inst_valid}, 32'd0);
    flush = 1'b1; flush_pc = 30'h0123;
    rst = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("idle_flush_req", {31'b0, imem_req}, 32'd1);
    check_eq("idle_flush_addr", {2'b0, imem_addr}, 32'h0000_0C00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
